// File: rtl/bcd_seg_scanner.sv
// Multiplexed seven-segment driver for DIGITS packed BCD digits: double-buffered
// capture, leading-zero blanking, dash for codes 10..15, fully registered pin outputs.
module bcd_seg_scanner #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       bcd_in,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] digit_idx
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  logic [3:0]        shadow_bcd [DIGITS];
  logic [DIGITS-1:0] shadow_dp;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;

  logic [DIGITS-1:0] blank_vec;
  logic              zero_above;
  logic [DIGITS-1:0] an_onehot;
  logic [6:0]        glyph;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [DIGITS-1:0] an_nxt;

  // Active-high segment pattern {g,f,e,d,c,b,a}; anything above 9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    blank_vec  = '0;
    zero_above = 1'b1;
    // A digit is dark only when it and every more significant digit are zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (shadow_bcd[i] == 4'd0);
      blank_vec[i] = blank_lz & zero_above;
    end

    glyph     = decode(shadow_bcd[idx]);
    an_onehot = DIGITS'(1) << idx;
    seg_nxt   = SEG_ACTIVE_LOW ? ~glyph : glyph;
    dp_nxt    = SEG_ACTIVE_LOW ? ~shadow_dp[idx] : shadow_dp[idx];
    an_nxt    = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;

    if (blank_vec[idx]) begin
      seg_nxt = SEG_OFF;
      dp_nxt  = DP_OFF;
      an_nxt  = AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shadow_dp <= '0;
      for (int i = 0; i < DIGITS; i++) shadow_bcd[i] <= 4'd0;
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // which is what gives the outputs their single cycle of lag behind idx/shadow.
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

      if (load) begin
        for (int i = 0; i < DIGITS; i++) shadow_bcd[i] <= bcd_in[4*i +: 4];
        shadow_dp <= dp_in;
      end

      digit_idx <= idx;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
      an        <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner: the driver pushes the expected pin state for each
// edge, a negedge monitor pops and compares. Model derives the lit digit from elapsed cycles.
module tb_bcd_seg_scanner;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  bcd_seg_scanner #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [1:0] idx;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: displayed digit comes from cycles elapsed since reset.
  int         n_since_rst = 0;
  logic [3:0] m_bcd [DIGITS];
  logic       m_dp  [DIGITS];

  function automatic logic [6:0] glyph(input int code);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (code < 10) ? tbl[code] : 7'h40;
  endfunction

  task automatic check(input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pins @%0t: got seg=%h dp=%b an=%h idx=%0d, expected seg=%h dp=%b an=%h idx=%0d",
               $time, got.seg, got.dp, got.an, got.idx, want.seg, want.dp, want.an, want.idx);
    end
  endtask

  // Drive one edge's inputs, predict the pins that edge produces, then advance.
  task automatic step(input logic r, input logic ld, input logic [15:0] b,
                      input logic [3:0] d, input logic blz);
    obs_t e;
    int   cur;
    bit   dark;
    rst = r; load = ld; bcd_in = b; dp_in = d; blank_lz = blz;
    if (r) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.idx = 2'd0;
      n_since_rst = 0;
      for (int i = 0; i < DIGITS; i++) begin m_bcd[i] = 4'd0; m_dp[i] = 1'b0; end
    end else begin
      cur  = (n_since_rst / SCAN_DIV) % DIGITS;
      dark = blz && (cur > 0);
      for (int j = cur; j < DIGITS; j++) if (m_bcd[j] != 4'd0) dark = 1'b0;
      e.idx = 2'(cur);
      if (dark) begin
        e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF;
      end else begin
        e.seg = ~glyph(int'(m_bcd[cur]));
        e.dp  = ~m_dp[cur];
        e.an  = ~(4'b0001 << cur);
      end
      if (ld) for (int i = 0; i < DIGITS; i++) begin
        m_bcd[i] = b[4*i +: 4];
        m_dp[i]  = d[i];
      end
      n_since_rst++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic blz);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom), blz);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < DIGITS; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  always @(negedge clk) begin
    obs_t got, want;
    if (exp_q.size() > 0) begin
      want    = exp_q.pop_front();
      got.seg = seg; got.dp = dp; got.an = an; got.idx = digit_idx;
      check(got, want);
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;

    // Reset, then scan of the cleared shadow.
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(6, 1'b0);

    // Full scan of 1234, no blanking, one decimal point.
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
    idle(12, 1'b0);

    // Leading-zero blanking, including the all-zero value.
    step(1'b0, 1'b1, 16'h0070, 4'b1000, 1'b1);
    idle(12, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 4'b1111, 1'b1);
    idle(12, 1'b1);

    // Invalid code shows a dash and is not treated as a leading zero.
    step(1'b0, 1'b1, 16'h00A5, 4'b0010, 1'b1);
    idle(12, 1'b1);

    // Load coinciding with a digit advance.
    while ((n_since_rst % SCAN_DIV) != SCAN_DIV - 1) idle(1, 1'b0);
    step(1'b0, 1'b1, 16'h9876, 4'b0001, 1'b0);
    idle(12, 1'b0);

    // Reset in the middle of a scan while digit 2 is selected.
    while (((n_since_rst / SCAN_DIV) % DIGITS) != 2) idle(1, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 4'hF, 1'b0);
    idle(12, 1'b0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), rand_bcd(),
           4'($urandom), 1'($urandom));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
